// File: rtl/obi_txn_buffer.sv
// OBI transaction buffer: queues primary requests in a small FIFO, presents
// them downstream as held requests, caps outstanding transactions, and forwards responses.
module obi_txn_buffer #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               s_req_i,
    output logic                               s_gnt_o,
    input  logic [31:0]                        s_addr_i,
    input  logic                               s_we_i,
    input  logic [3:0]                         s_be_i,
    input  logic [31:0]                        s_wdata_i,
    output logic                               s_rvalid_o,
    output logic [31:0]                        s_rdata_o,
    output logic                               m_req_o,
    input  logic                               m_gnt_i,
    output logic [31:0]                        m_addr_o,
    output logic                               m_we_o,
    output logic [3:0]                         m_be_o,
    output logic [31:0]                        m_wdata_o,
    input  logic                               m_rvalid_i,
    input  logic [31:0]                        m_rdata_i,
    output logic [$clog2(DEPTH):0]             count_o,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } payload_t;

    payload_t        mem [DEPTH];
    payload_t        head;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [OW-1:0]   outst_q;
    logic            err_q;
    logic            rvalid_q;
    logic [31:0]     rdata_q;

    logic            full;
    logic            empty;
    logic            at_cap;
    logic            push;
    logic            pop;

    // Handshakes on both sides are OBI req/gnt: a transfer happens in the cycle
    // where req and gnt are both high; req and payload stay stable until then,
    // and gnt seen without req has no effect.
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign at_cap  = (outst_q == OW'(MAX_OUTSTANDING));

    // Refusal when full is independent of a same-cycle pop: no pass-through path.
    assign s_gnt_o = s_req_i && !full;
    assign push    = s_req_i && s_gnt_o;
    assign m_req_o = !empty && !at_cap;
    assign pop     = m_req_o && m_gnt_i;

    assign head      = mem[rd_ptr_q];
    assign m_addr_o  = head.addr;
    assign m_we_o    = head.we;
    assign m_be_o    = head.be;
    assign m_wdata_o = head.wdata;

    assign count_o       = count_q;
    assign outstanding_o = outst_q;
    assign err_o         = err_q;
    assign s_rvalid_o    = rvalid_q;
    assign s_rdata_o     = rdata_q;

    // Storage carries no reset; its contents only matter while count_q != 0.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= payload_t'{addr: s_addr_i, we: s_we_i, be: s_be_i, wdata: s_wdata_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A response with nothing outstanding cannot belong to a same-cycle grant,
    // so it is flagged as an error and the counter saturates at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (pop && !m_rvalid_i) begin
                outst_q <= outst_q + OW'(1);
            end else if (!pop && m_rvalid_i && (outst_q != '0)) begin
                outst_q <= outst_q - OW'(1);
            end
            if (m_rvalid_i && (outst_q == '0)) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= m_rvalid_i;
            if (m_rvalid_i) rdata_q <= m_rdata_i;
        end
    end

endmodule

// File: tb/tb_obi_txn_buffer.sv
// Directed bench for obi_txn_buffer with DEPTH=4 and MAX_OUTSTANDING=2.
module tb_obi_txn_buffer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        s_req_i;
    logic        s_gnt_o;
    logic [31:0] s_addr_i;
    logic        s_we_i;
    logic [3:0]  s_be_i;
    logic [31:0] s_wdata_i;
    logic        s_rvalid_o;
    logic [31:0] s_rdata_o;
    logic        m_req_o;
    logic        m_gnt_i;
    logic [31:0] m_addr_o;
    logic        m_we_o;
    logic [3:0]  m_be_o;
    logic [31:0] m_wdata_o;
    logic        m_rvalid_i;
    logic [31:0] m_rdata_i;
    logic [2:0]  count_o;
    logic [1:0]  outstanding_o;
    logic        err_o;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr;

    obi_txn_buffer #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_req_i(s_req_i), .s_gnt_o(s_gnt_o), .s_addr_i(s_addr_i), .s_we_i(s_we_i),
        .s_be_i(s_be_i), .s_wdata_i(s_wdata_i), .s_rvalid_o(s_rvalid_o), .s_rdata_o(s_rdata_o),
        .m_req_o(m_req_o), .m_gnt_i(m_gnt_i), .m_addr_o(m_addr_o), .m_we_o(m_we_o),
        .m_be_o(m_be_o), .m_wdata_o(m_wdata_o), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
        .count_o(count_o), .outstanding_o(outstanding_o), .err_o(err_o)
    );

    // Clock; inputs change and outputs are sampled just after the falling edge.
    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        s_req_i = 0; s_addr_i = '0; s_we_i = 0; s_be_i = '0; s_wdata_i = '0;
        m_gnt_i = 0; m_rvalid_i = 0; m_rdata_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 0;
        cyc();
        cyc();
        rst_ni = 1;
        exp_q.delete();
    endtask

    task automatic push(input logic [31:0] addr, input logic we);
        s_req_i = 1; s_addr_i = addr; s_we_i = we; s_be_i = 4'hF; s_wdata_i = ~addr;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 0;
        s_req_i = 1;
        #1;
        checks++; if (s_gnt_o !== 1'b1) begin failures++; $display("FAIL reset_gnt got=%b exp=1", s_gnt_o); end
        checks++; if (m_req_o !== 1'b0) begin failures++; $display("FAIL reset_mreq got=%b exp=0", m_req_o); end
        checks++; if (count_o !== 3'd0 || outstanding_o !== 2'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", count_o, outstanding_o); end
        checks++; if (s_rvalid_o !== 1'b0 || s_rdata_o !== 32'h0 || err_o !== 1'b0) begin failures++; $display("FAIL reset_resp got=%b/%h/%b exp=0/0/0", s_rvalid_o, s_rdata_o, err_o); end
        do_reset();
    endtask

    task automatic test_single_read();
        push(32'h1000, 0);                                   // cycle 0
        cyc();
        s_req_i = 0;                                         // cycle 1
        #1;
        checks++; if (m_req_o !== 1'b1 || m_addr_o !== 32'h1000) begin failures++; $display("FAIL single_req1 got=%b/%h exp=1/00001000", m_req_o, m_addr_o); end
        cyc();                                               // cycle 2
        #1;
        checks++; if (m_req_o !== 1'b1 || m_addr_o !== 32'h1000) begin failures++; $display("FAIL single_req2 got=%b/%h exp=1/00001000", m_req_o, m_addr_o); end
        cyc();                                               // cycle 3
        m_gnt_i = 1;
        #1;
        checks++; if (m_req_o !== 1'b1) begin failures++; $display("FAIL single_req3 got=%b exp=1", m_req_o); end
        cyc();                                               // cycle 4
        m_gnt_i = 0;
        #1;
        checks++; if (m_req_o !== 1'b0 || outstanding_o !== 2'd1) begin failures++; $display("FAIL single_issued got=%b/%0d exp=0/1", m_req_o, outstanding_o); end
        cyc();
        cyc();                                               // cycle 6
        m_rvalid_i = 1; m_rdata_i = 32'hDEADBEEF;
        #1;
        checks++; if (outstanding_o !== 2'd1 || s_rvalid_o !== 1'b0) begin failures++; $display("FAIL single_c6 got=%0d/%b exp=1/0", outstanding_o, s_rvalid_o); end
        cyc();                                               // cycle 7
        m_rvalid_i = 0; m_rdata_i = 32'h0;
        #1;
        checks++; if (s_rvalid_o !== 1'b1 || s_rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL single_resp got=%b/%h exp=1/deadbeef", s_rvalid_o, s_rdata_o); end
        checks++; if (outstanding_o !== 2'd0 || err_o !== 1'b0) begin failures++; $display("FAIL single_done got=%0d/%b exp=0/0", outstanding_o, err_o); end
        cyc();
        #1;
        checks++; if (s_rvalid_o !== 1'b0 || s_rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL single_hold got=%b/%h exp=0/deadbeef", s_rvalid_o, s_rdata_o); end
        do_reset();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            push(32'h100 + 32'(i * 4), 0);
            exp_q.push_back(32'h100 + 32'(i * 4));
            #1;
            checks++; if (s_gnt_o !== 1'b1) begin failures++; $display("FAIL fill_gnt%0d got=%b exp=1", i, s_gnt_o); end
            cyc();
        end
        push(32'h110, 0);
        m_gnt_i = 1;
        #1;
        checks++; if (s_gnt_o !== 1'b0 || count_o !== 3'd4) begin failures++; $display("FAIL fill_full got=%b/%0d exp=0/4", s_gnt_o, count_o); end
        exp_addr = exp_q.pop_front();
        checks++; if (m_addr_o !== exp_addr) begin failures++; $display("FAIL fill_head got=%h exp=%h", m_addr_o, exp_addr); end
        cyc();
        m_gnt_i = 0;
        #1;
        checks++; if (s_gnt_o !== 1'b1 || count_o !== 3'd3) begin failures++; $display("FAIL fill_regrant got=%b/%0d exp=1/3", s_gnt_o, count_o); end
        checks++; if (m_addr_o !== exp_q[0]) begin failures++; $display("FAIL fill_next got=%h exp=%h", m_addr_o, exp_q[0]); end
        cyc();
        s_req_i = 0;
        #1;
        checks++; if (count_o !== 3'd4 || outstanding_o !== 2'd1) begin failures++; $display("FAIL fill_end got=%0d/%0d exp=4/1", count_o, outstanding_o); end
        do_reset();
    endtask

    task automatic test_outstanding_cap();
        m_gnt_i = 1;
        for (int i = 0; i < 4; i++) begin
            push(32'h200 + 32'(i * 4), 1);
            cyc();
        end
        s_req_i = 0;
        #1;
        checks++; if (m_req_o !== 1'b0 || count_o !== 3'd2 || outstanding_o !== 2'd2) begin failures++; $display("FAIL cap_stall got=%b/%0d/%0d exp=0/2/2", m_req_o, count_o, outstanding_o); end
        m_rvalid_i = 1; m_rdata_i = 32'h0;
        cyc();
        m_rvalid_i = 0;
        #1;
        checks++; if (m_req_o !== 1'b1 || m_addr_o !== 32'h208 || m_we_o !== 1'b1) begin failures++; $display("FAIL cap_resume got=%b/%h/%b exp=1/00000208/1", m_req_o, m_addr_o, m_we_o); end
        checks++; if (m_wdata_o !== ~32'h208 || m_be_o !== 4'hF || outstanding_o !== 2'd1) begin failures++; $display("FAIL cap_payload got=%h/%h/%0d exp=%h/f/1", m_wdata_o, m_be_o, outstanding_o, ~32'h208); end
        do_reset();
    endtask

    task automatic test_simultaneous();
        push(32'h300, 0);
        cyc();
        push(32'h304, 0);
        m_gnt_i = 1;
        cyc();
        s_req_i = 0;
        m_rvalid_i = 1; m_rdata_i = 32'h1234_5678;
        #1;
        checks++; if (outstanding_o !== 2'd1 || m_req_o !== 1'b1) begin failures++; $display("FAIL simul_pre got=%0d/%b exp=1/1", outstanding_o, m_req_o); end
        cyc();
        m_gnt_i = 0; m_rvalid_i = 0;
        #1;
        checks++; if (outstanding_o !== 2'd1 || count_o !== 3'd0 || err_o !== 1'b0) begin failures++; $display("FAIL simul_post got=%0d/%0d/%b exp=1/0/0", outstanding_o, count_o, err_o); end
        checks++; if (s_rvalid_o !== 1'b1 || s_rdata_o !== 32'h1234_5678) begin failures++; $display("FAIL simul_resp got=%b/%h exp=1/12345678", s_rvalid_o, s_rdata_o); end
        do_reset();
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 2; k++) begin
                push(32'((2 * r + k) * 4), 0);
                exp_q.push_back(32'((2 * r + k) * 4));
                #1;
                checks++; if (s_gnt_o !== 1'b1) begin failures++; $display("FAIL wrap_gnt got=%b exp=1", s_gnt_o); end
                cyc();
            end
            s_req_i = 0;
            for (int k = 0; k < 2; k++) begin
                m_gnt_i = 1;
                m_rvalid_i = (k == 1);
                m_rdata_i = 32'(r);
                exp_addr = exp_q.pop_front();
                #1;
                checks++; if (m_req_o !== 1'b1 || m_addr_o !== exp_addr) begin failures++; $display("FAIL wrap_order got=%b/%h exp=1/%h", m_req_o, m_addr_o, exp_addr); end
                cyc();
            end
            m_gnt_i = 0; m_rvalid_i = 1;
            cyc();
            m_rvalid_i = 0;
            #1;
            checks++; if (outstanding_o !== 2'd0 || count_o !== 3'd0 || err_o !== 1'b0) begin failures++; $display("FAIL wrap_drain got=%0d/%0d/%b exp=0/0/0", outstanding_o, count_o, err_o); end
        end
        do_reset();
    endtask

    task automatic test_spurious();
        m_rvalid_i = 1; m_rdata_i = 32'h55;
        cyc();
        m_rvalid_i = 0;
        #1;
        checks++; if (err_o !== 1'b1 || outstanding_o !== 2'd0) begin failures++; $display("FAIL spur_err got=%b/%0d exp=1/0", err_o, outstanding_o); end
        checks++; if (s_rvalid_o !== 1'b1 || s_rdata_o !== 32'h55) begin failures++; $display("FAIL spur_fwd got=%b/%h exp=1/00000055", s_rvalid_o, s_rdata_o); end
        cyc();
        cyc();
        #1;
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL spur_sticky got=%b exp=1", err_o); end
        do_reset();
        #1;
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL spur_clear got=%b exp=0", err_o); end
    endtask

    task automatic test_async_reset();
        m_rvalid_i = 1; m_rdata_i = 32'hA5A5;      // spurious: sets err
        push(32'h400, 0);
        cyc();
        m_rvalid_i = 0;
        for (int i = 1; i < 4; i++) begin
            push(32'h400 + 32'(i * 4), 0);
            cyc();
        end
        s_req_i = 0;
        m_gnt_i = 1;
        cyc();
        cyc();
        m_gnt_i = 0;
        push(32'h410, 0);
        cyc();
        s_req_i = 0;
        #1;
        checks++; if (count_o !== 3'd3 || outstanding_o !== 2'd2 || err_o !== 1'b1 || s_rdata_o !== 32'hA5A5) begin failures++; $display("FAIL arst_pre got=%0d/%0d/%b/%h exp=3/2/1/0000a5a5", count_o, outstanding_o, err_o, s_rdata_o); end
        #1;
        rst_ni = 0;
        s_req_i = 1;
        #1;
        checks++; if (count_o !== 3'd0 || outstanding_o !== 2'd0 || err_o !== 1'b0 || s_rdata_o !== 32'h0 || s_rvalid_o !== 1'b0) begin failures++; $display("FAIL arst_now got=%0d/%0d/%b/%h/%b exp=0/0/0/0/0", count_o, outstanding_o, err_o, s_rdata_o, s_rvalid_o); end
        checks++; if (m_req_o !== 1'b0 || s_gnt_o !== 1'b1) begin failures++; $display("FAIL arst_hs got=%b/%b exp=0/1", m_req_o, s_gnt_o); end
        s_req_i = 0;
        cyc();
        rst_ni = 1;
        m_rvalid_i = 1; m_rdata_i = 32'h77;
        cyc();
        m_rvalid_i = 0;
        #1;
        checks++; if (err_o !== 1'b1 || s_rvalid_o !== 1'b1) begin failures++; $display("FAIL arst_late got=%b/%b exp=1/1", err_o, s_rvalid_o); end
        do_reset();
    endtask

    initial begin
        idle_inputs();
        rst_ni = 0;
        @(negedge clk_i);
        test_reset();
        test_single_read();
        test_fill();
        test_outstanding_cap();
        test_simultaneous();
        test_wrap();
        test_spurious();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
